// File: rtl/xfer_ctl.sv
// Transfer-control sequencer: free-running drum bit/word timing, command register,
// source/destination select decode and the TR window / DONE pulse for one transfer.
module xfer_ctl #(
   parameter int BITS_PER_WORD  = 29,
   parameter int WORDS_PER_LINE = 108
) (
   input  logic       CLOCK,
   input  logic       rst,
   input  logic       CMD_VALID,
   input  logic [4:0] CMD_S,
   input  logic [4:0] CMD_D,
   input  logic [6:0] CMD_T,
   input  logic       CMD_I,
   output logic [4:0] BT,
   output logic [6:0] WT,
   output logic       BUSY,
   output logic       TR,
   output logic       S0,
   output logic       S1,
   output logic       SU,
   output logic       SV,
   output logic       SW,
   output logic       SX,
   output logic       D0,
   output logic       D1,
   output logic       DU,
   output logic       DV,
   output logic       DW,
   output logic       DX,
   output logic       SSPEC,
   output logic       DSPEC,
   output logic       DONE
);

   localparam logic [4:0] BT_LAST = 5'(BITS_PER_WORD - 1);
   localparam logic [6:0] WT_LAST = 7'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_XFER
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [4:0] bt;
   logic [6:0] wt;
   logic [4:0] cmd_s;
   logic [4:0] cmd_d;
   logic [6:0] cmd_t;
   logic       cmd_i;
   logic [6:0] last_word;
   logic       start_go;
   logic       end_go;
   logic       accept;
   logic       active;

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         bt <= '0;
         wt <= '0;
      end else if (bt == BT_LAST) begin
         bt <= '0;
         wt <= (wt == WT_LAST) ? '0 : wt + 7'd1;
      end else begin
         bt <= bt + 5'd1;
      end
   end

   // An immediate transfer runs up to the word before T; T equal to the start
   // word therefore naturally yields a full revolution.
   always_comb begin
      last_word = cmd_t;
      if (cmd_i) begin
         last_word = (cmd_t == 7'd0) ? WT_LAST : cmd_t - 7'd1;
      end
      start_go = (state == ST_WAIT) && (bt == 5'd0) && (cmd_i || (wt == cmd_t));
      end_go   = (state == ST_XFER) && (bt == BT_LAST) && (wt == last_word);
      accept   = CMD_VALID && ((state == ST_IDLE) || end_go);
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_WAIT;
         ST_WAIT: if (start_go) state_next = ST_XFER;
         ST_XFER: if (end_go) state_next = accept ? ST_WAIT : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         cmd_s <= '0;
         cmd_d <= '0;
         cmd_t <= '0;
         cmd_i <= 1'b0;
      end else if (accept) begin
         cmd_s <= CMD_S;
         cmd_d <= CMD_D;
         cmd_t <= CMD_T;
         cmd_i <= CMD_I;
      end
   end

   // The boundary cycle that launches a transfer is still in WAIT, so TR
   // covers it combinationally; the XFER state carries the rest of the window.
   always_comb begin
      active = (state != ST_IDLE);
      BT     = bt;
      WT     = wt;
      BUSY   = active;
      TR     = (state == ST_XFER) || start_go;
      DONE   = end_go && !rst;
      SSPEC  = active && (cmd_s >= 5'd8);
      S0     = active && (cmd_s[4:2] == 3'd0);
      S1     = active && (cmd_s[4:2] == 3'd1);
      SU     = active && !SSPEC && (cmd_s[1:0] == 2'd0);
      SV     = active && !SSPEC && (cmd_s[1:0] == 2'd1);
      SW     = active && !SSPEC && (cmd_s[1:0] == 2'd2);
      SX     = active && !SSPEC && (cmd_s[1:0] == 2'd3);
      DSPEC  = active && (cmd_d >= 5'd8);
      D0     = active && (cmd_d[4:2] == 3'd0);
      D1     = active && (cmd_d[4:2] == 3'd1);
      DU     = active && !DSPEC && (cmd_d[1:0] == 2'd0);
      DV     = active && !DSPEC && (cmd_d[1:0] == 2'd1);
      DW     = active && !DSPEC && (cmd_d[1:0] == 2'd2);
      DX     = active && !DSPEC && (cmd_d[1:0] == 2'd3);
   end

endmodule

// File: tb/tb_xfer_ctl.sv
// Self-checking bench for xfer_ctl: directed drum-timing scenarios plus random
// commands, compared every cycle against a cycle-count based transfer model.
module tb_xfer_ctl;

   logic       clock = 1'b0;
   logic       rst;
   logic       cmdValid;
   logic [4:0] cmdS;
   logic [4:0] cmdD;
   logic [6:0] cmdT;
   logic       cmdI;
   logic [4:0] bt;
   logic [6:0] wt;
   logic       busy, tr, done;
   logic       s0, s1, su, sv, sw, sx, sspec;
   logic       d0, d1, du, dv, dw, dx, dspec;

   int         checkCount = 0;
   int         passCount = 0;
   int         n = 0;
   bit         mBusy = 0;
   bit         mHasStart = 0;
   int         mStart = 0;
   int         mEnd = 0;
   logic [4:0] mS = '0;
   logic [4:0] mD = '0;

   xfer_ctl dut (
      .CLOCK(clock), .rst(rst), .CMD_VALID(cmdValid), .CMD_S(cmdS), .CMD_D(cmdD),
      .CMD_T(cmdT), .CMD_I(cmdI), .BT(bt), .WT(wt), .BUSY(busy), .TR(tr),
      .S0(s0), .S1(s1), .SU(su), .SV(sv), .SW(sw), .SX(sx),
      .D0(d0), .D1(d1), .DU(du), .DV(dv), .DW(dw), .DX(dx),
      .SSPEC(sspec), .DSPEC(dspec), .DONE(done)
   );

   always #5 clock = ~clock;

   function automatic int wordOf(input int c);
      return (c / 29) % 108;
   endfunction

   // Select pattern a line code should produce: {grp0, grp1, U, V, W, X, spec}
   function automatic logic [6:0] selBits(input logic [4:0] code);
      int c;
      bit spec;
      c = int'(code);
      spec = (c >= 8);
      return {c / 4 == 0, c / 4 == 1, !spec && c % 4 == 0, !spec && c % 4 == 1,
              !spec && c % 4 == 2, !spec && c % 4 == 3, spec};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, n);
   endtask

   task automatic compareAll();
      bit expTr, expDone;
      expTr   = mBusy && mHasStart && n >= mStart && n <= mEnd;
      expDone = mBusy && mHasStart && n == mEnd;
      checkOutput("bt", 32'(bt), 32'(n % 29));
      checkOutput("wt", 32'(wt), 32'(wordOf(n)));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("tr", 32'(tr), 32'(expTr));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("src", 32'({s0, s1, su, sv, sw, sx, sspec}), 32'(mBusy ? selBits(mS) : 7'd0));
      checkOutput("dst", 32'({d0, d1, du, dv, dw, dx, dspec}), 32'(mBusy ? selBits(mD) : 7'd0));
   endtask

   // Called at a falling edge: check the current cycle, drive the inputs that
   // the next rising edge samples, and advance the model across that edge.
   task automatic applyStimulus(input logic v, input logic [4:0] s, input logic [4:0] d,
                                input logic [6:0] t, input logic i, input logic r);
      int k, ws, len;
      bit canAccept;
      compareAll();
      cmdValid = v; cmdS = s; cmdD = d; cmdT = t; cmdI = i; rst = r;
      if (r) begin
         mBusy = 0;
         mHasStart = 0;
         mS = '0;
         mD = '0;
      end else begin
         canAccept = !mBusy || (mHasStart && n == mEnd);
         if (mBusy && mHasStart && n == mEnd) mBusy = 0;
         if (v && canAccept) begin
            mBusy = 1;
            mS = s;
            mD = d;
            k = (n / 29 + 1) * 29;
            if (i) begin
               ws = wordOf(k);
               len = (int'(t) + 108 - ws) % 108;
               if (len == 0) len = 108;
               mHasStart = 1;
               mStart = k;
               mEnd = k + len * 29 - 1;
            end else if (t > 7'd107) begin
               mHasStart = 0;
            end else begin
               while (wordOf(k) != int'(t)) k += 29;
               mHasStart = 1;
               mStart = k;
               mEnd = k + 28;
            end
         end
      end
      @(negedge clock);
      n = r ? 0 : n + 1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b0);
   endtask

   task automatic goTo(input int b, input int w);
      for (int j = 0; j < 3200 && !(n % 29 == b && wordOf(n) == w); j++) idle();
   endtask

   task automatic runUntilIdle();
      for (int j = 0; j < 3300 && mBusy; j++) idle();
      repeat (3) idle();
   endtask

   task automatic runUntil(input int target);
      for (int j = 0; j < 3300 && n < target; j++) idle();
   endtask

   initial begin
      logic [6:0] tNext;
      rst = 1'b1; cmdValid = 1'b0; cmdS = '0; cmdD = '0; cmdT = '0; cmdI = 1'b0;
      repeat (3) @(negedge clock);
      n = 0;

      // One full revolution idle: counters wrap once, everything else quiet
      repeat (3133) idle();

      // Deferred S=2 D=5 T=10 accepted at WT=3 BT=7
      goTo(7, 3);
      applyStimulus(1'b1, 5'd2, 5'd5, 7'd10, 1'b0, 1'b0);
      runUntilIdle();

      // Immediate S=0 D=3 T=4 accepted at WT=105 BT=12: words 106..3
      goTo(12, 105);
      applyStimulus(1'b1, 5'd0, 5'd3, 7'd4, 1'b1, 1'b0);
      runUntilIdle();

      // Immediate with T equal to the start word: full revolution
      goTo(5, 20);
      applyStimulus(1'b1, 5'd3, 5'd3, 7'd21, 1'b1, 1'b0);
      runUntilIdle();

      // Deferred accepted on the boundary of its own word: one revolution late
      goTo(0, 50);
      applyStimulus(1'b1, 5'd9, 5'd17, 7'd50, 1'b0, 1'b0);
      runUntilIdle();

      // Command pulsed mid-transfer is ignored; one on the DONE cycle is taken
      goTo(3, 30);
      applyStimulus(1'b1, 5'd1, 5'd6, 7'd33, 1'b0, 1'b0);
      runUntil(mStart + 10);
      applyStimulus(1'b1, 5'd24, 5'd31, 7'd5, 1'b1, 1'b0);
      runUntil(mEnd);
      tNext = 7'((wordOf(n) + 3) % 108);
      applyStimulus(1'b1, 5'd24, 5'd2, tNext, 1'b1, 1'b0);
      runUntilIdle();

      // Reset on the 15th TR cycle aborts without DONE; S=24 is a special code
      goTo(20, 40);
      applyStimulus(1'b1, 5'd24, 5'd12, 7'd45, 1'b1, 1'b0);
      runUntil(mStart + 14);
      applyStimulus(1'b0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b1);
      repeat (40) idle();

      // Out-of-range deferred timing number stays pending until reset
      applyStimulus(1'b1, 5'd5, 5'd5, 7'd120, 1'b0, 1'b0);
      repeat (300) idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b1);
      repeat (5) idle();

      // Random commands, mostly aimed a few words ahead to keep the run short
      for (int c = 0; c < 12000; c++) begin
         logic v, r, i;
         logic [6:0] t;
         r = ($urandom_range(0, 2999) == 0);
         v = ($urandom_range(0, 15) == 0);
         i = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) t = 7'($urandom_range(0, 107));
         else t = 7'((wordOf(n) + int'($urandom_range(0, 3))) % 108);
         applyStimulus(v, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), t, i, r);
      end
      runUntilIdle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
